// File: rtl/cfg_counter.sv
// ----------------------------------------------------------------------------
// cfg_counter
//   Up/down counter with a programmable terminal value. The count runs over
//   0..max_val. At either limit it wraps (SAT_MODE=0) or saturates
//   (SAT_MODE=1). Every limit event produces a one-cycle ovf/unf pulse and
//   sets a sticky flag.
//
// Parameters
//   WIDTH      counter width in bits (2..32)
//   SAT_MODE   0 = wrap at limits, 1 = saturate at limits
//
// Ports
//   clk          clock; all state changes on its rising edge
//   reset        asynchronous active-high reset
//   en           count enable
//   up           direction: 1 = increment, 0 = decrement
//   clr          synchronous clear (highest priority)
//   load         synchronous load of min(load_val, max_val)
//   load_val     value to load
//   max_val      terminal value; the count range is 0..max_val
//   sticky_clr   clears both sticky flags (a new event in the same cycle wins)
//   count        registered counter value
//   ovf / unf    registered one-cycle pulses on up- and down-limit events
//   ovf_sticky   latched overflow flag
//   unf_sticky   latched underflow flag
//   at_max       count >= max_val (combinational)
//   at_zero      count == 0 (combinational)
// ----------------------------------------------------------------------------
module cfg_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter bit          SAT_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   input  logic             sticky_clr,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic             unf,
   output logic             ovf_sticky,
   output logic             unf_sticky,
   output logic             at_max,
   output logic             at_zero
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic             unf_sticky_q, unf_sticky_d;

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;

      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = (load_val > max_val) ? max_val : load_val;
      end else if (en) begin
         if (up) begin
            // ">=" rather than "==": if max_val has been lowered below the
            // current count, an up step is treated as hitting the limit.
            if (count_q >= max_val) begin
               ovf_d   = 1'b1;
               count_d = SAT_MODE ? max_val : '0;
            end else begin
               count_d = count_q + ONE;
            end
         end else begin
            if (count_q == '0) begin
               unf_d   = 1'b1;
               count_d = SAT_MODE ? '0 : max_val;
            end else begin
               count_d = count_q - ONE;
            end
         end
      end

      // A new event takes precedence over a clear in the same cycle.
      ovf_sticky_d = ovf_d | (ovf_sticky_q & ~sticky_clr);
      unf_sticky_d = unf_d | (unf_sticky_q & ~sticky_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q      <= '0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         ovf_sticky_q <= 1'b0;
         unf_sticky_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
         ovf_sticky_q <= ovf_sticky_d;
         unf_sticky_q <= unf_sticky_d;
      end
   end

   assign count      = count_q;
   assign ovf        = ovf_q;
   assign unf        = unf_q;
   assign ovf_sticky = ovf_sticky_q;
   assign unf_sticky = unf_sticky_q;
   assign at_max     = (count_q >= max_val);
   assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_cfg_counter.sv
// ----------------------------------------------------------------------------
// tb_cfg_counter
//   Three instances share one stimulus stream:
//     k=0  WIDTH=8 SAT_MODE=0
//     k=1  WIDTH=8 SAT_MODE=1
//     k=2  WIDTH=4 SAT_MODE=0  (driven with the low nibble of load_val/max_val)
//   A behavioural model written with integer arithmetic tracks all three.
//   A table of hand-computed vectors checks instance 0. Short hand-written
//   sequences cover the multi-cycle corner cases, and a random phase follows.
// ----------------------------------------------------------------------------
module tb_cfg_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, up, clr, load, sticky_clr;
   logic [7:0] load_val, max_val;

   logic [7:0] c0, c1;
   logic [3:0] c2;
   logic       o0, o1, o2, u0, u1, u2;
   logic       os0, os1, os2, us0, us1, us2;
   logic       am0, am1, am2, az0, az1, az2;

   int vectors = 0;
   int errors  = 0;

   cfg_counter #(.WIDTH(8), .SAT_MODE(1'b0)) u_w8 (
      .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .max_val(max_val), .sticky_clr(sticky_clr),
      .count(c0), .ovf(o0), .unf(u0), .ovf_sticky(os0), .unf_sticky(us0),
      .at_max(am0), .at_zero(az0));

   cfg_counter #(.WIDTH(8), .SAT_MODE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .max_val(max_val), .sticky_clr(sticky_clr),
      .count(c1), .ovf(o1), .unf(u1), .ovf_sticky(os1), .unf_sticky(us1),
      .at_max(am1), .at_zero(az1));

   cfg_counter #(.WIDTH(4), .SAT_MODE(1'b0)) u_w4 (
      .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val[3:0]), .max_val(max_val[3:0]), .sticky_clr(sticky_clr),
      .count(c2), .ovf(o2), .unf(u2), .ovf_sticky(os2), .unf_sticky(us2),
      .at_max(am2), .at_zero(az2));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int ws[3]  = '{8, 8, 4};
   int sat[3] = '{0, 1, 0};
   int m_cnt[3], m_ovf[3], m_unf[3], m_os[3], m_us[3];

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_os[k] = 0; m_us[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int top, lv, mv, nxt, ev_o, ev_u;
         top  = (1 << ws[k]) - 1;
         lv   = int'(load_val) & top;
         mv   = int'(max_val) & top;
         nxt  = m_cnt[k];
         ev_o = 0;
         ev_u = 0;
         if (clr)       nxt = 0;
         else if (load) nxt = (lv < mv) ? lv : mv;
         else if (en) begin
            if (up) begin
               if (m_cnt[k] >= mv) begin ev_o = 1; nxt = sat[k] ? mv : 0; end
               else nxt = m_cnt[k] + 1;
            end else begin
               if (m_cnt[k] == 0) begin ev_u = 1; nxt = sat[k] ? 0 : mv; end
               else nxt = m_cnt[k] - 1;
            end
         end
         m_cnt[k] = nxt;
         m_ovf[k] = ev_o;
         m_unf[k] = ev_u;
         m_os[k]  = (ev_o != 0 || (m_os[k] != 0 && !sticky_clr)) ? 1 : 0;
         m_us[k]  = (ev_u != 0 || (m_us[k] != 0 && !sticky_clr)) ? 1 : 0;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic get_dut(input int k, output int c, output int o, output int u,
                          output int os, output int us, output int am, output int az);
      case (k)
         0:       begin c = int'(c0); o = int'(o0); u = int'(u0); os = int'(os0); us = int'(us0); am = int'(am0); az = int'(az0); end
         1:       begin c = int'(c1); o = int'(o1); u = int'(u1); os = int'(os1); us = int'(us1); am = int'(am1); az = int'(az1); end
         default: begin c = int'(c2); o = int'(o2); u = int'(u2); os = int'(os2); us = int'(us2); am = int'(am2); az = int'(az2); end
      endcase
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 3; k++) begin
         int c, o, u, os, us, am, az, mv;
         get_dut(k, c, o, u, os, us, am, az);
         mv = int'(max_val) & ((1 << ws[k]) - 1);
         chk($sformatf("%s.k%0d.count", tag, k),   c,  m_cnt[k]);
         chk($sformatf("%s.k%0d.ovf", tag, k),     o,  m_ovf[k]);
         chk($sformatf("%s.k%0d.unf", tag, k),     u,  m_unf[k]);
         chk($sformatf("%s.k%0d.ovf_st", tag, k),  os, m_os[k]);
         chk($sformatf("%s.k%0d.unf_st", tag, k),  us, m_us[k]);
         chk($sformatf("%s.k%0d.at_max", tag, k),  am, (m_cnt[k] >= mv) ? 1 : 0);
         chk($sformatf("%s.k%0d.at_zero", tag, k), az, (m_cnt[k] == 0) ? 1 : 0);
      end
   endtask

   task automatic drive(input logic c, input logic l, input logic e, input logic u,
                        input logic s, input logic [7:0] lv, input logic [7:0] mv);
      clr = c; load = l; en = e; up = u; sticky_clr = s; load_val = lv; max_val = mv;
   endtask

   // One clock: update the model at the edge, sample 1 ns later.
   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   // ---------------- directed table (instance 0: WIDTH=8, wrap) ----------------
   typedef struct {
      logic       clr, load, en, up, sclr;
      logic [7:0] lv, mv;
      int         e_cnt, e_ovf, e_unf, e_os, e_us;
   } vec_t;

   vec_t tbl[21];

   initial begin
      //            clr   load  en    up    sclr  lv   mv    cnt o  u  os us
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,   9,    9,  0, 1, 0, 1};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,   9,    8,  0, 0, 0, 1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7,   9,    0,  0, 0, 0, 1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7,   4,    4,  0, 0, 0, 1};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0,   4,    0,  1, 0, 1, 1};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0,   4,    1,  0, 0, 0, 0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3,   4,    3,  0, 0, 0, 0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0,   4,    4,  0, 0, 0, 0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0,   4,    0,  1, 0, 1, 0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,   4,    0,  0, 0, 0, 0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 200, 255,  200, 0, 0, 0, 0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0,   100,  0,  1, 0, 1, 0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 50,  255,  50, 0, 0, 1, 0};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,   10,   49, 0, 0, 1, 0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,   10,   49, 0, 0, 1, 0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,   10,   0,  0, 0, 1, 0};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0,   0,    0,  1, 0, 1, 0};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,   0,    0,  0, 1, 1, 1};
      tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 255, 255,  255, 0, 0, 1, 1};
      tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0,   255,  0,  1, 0, 1, 1};
      tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,   255,  255, 0, 1, 1, 1};
   end

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 8'd0, 8'd0);
      model_reset();
      #2;
      check_all("reset");
      #19 reset = 1'b0;

      // Table vectors
      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].sclr, tbl[i].lv, tbl[i].mv);
         step($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.count", i),  int'(c0),  tbl[i].e_cnt);
         chk($sformatf("tbl%0d.ovf", i),    int'(o0),  tbl[i].e_ovf);
         chk($sformatf("tbl%0d.unf", i),    int'(u0),  tbl[i].e_unf);
         chk($sformatf("tbl%0d.ovf_st", i), int'(os0), tbl[i].e_os);
         chk($sformatf("tbl%0d.unf_st", i), int'(us0), tbl[i].e_us);
      end

      // WIDTH=4 full-range wrap: 17 up steps from 0 with max_val=15
      drive(1, 0, 0, 0, 1, 8'd0, 8'd15);
      step("w4_prep");
      for (int i = 1; i <= 17; i++) begin
         drive(0, 0, 1, 1, 0, 8'd0, 8'd15);
         step($sformatf("w4_up%0d", i));
         chk($sformatf("w4_up%0d.count", i),  int'(c2),  i % 16);
         chk($sformatf("w4_up%0d.ovf", i),    int'(o2),  (i == 16) ? 1 : 0);
         chk($sformatf("w4_up%0d.ovf_st", i), int'(os2), (i >= 16) ? 1 : 0);
      end

      // Saturation at max_val=5, three up steps
      drive(0, 1, 0, 0, 1, 8'd5, 8'd5);
      step("sat_load");
      chk("sat_load.count", int'(c1), 5);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 1, 0, 8'd0, 8'd5);
         step($sformatf("sat_up%0d", i));
         chk($sformatf("sat_up%0d.count", i), int'(c1), 5);
         chk($sformatf("sat_up%0d.ovf", i),   int'(o1), 1);
      end

      // Asynchronous reset mid-cycle with count=3
      drive(0, 1, 0, 0, 0, 8'd3, 8'd20);
      step("ar_load");
      chk("ar_load.count", int'(c0), 3);
      drive(0, 0, 1, 1, 0, 8'd0, 8'd20);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_all("ar_asserted");
      chk("ar_asserted.count", int'(c0), 0);
      #1 reset = 1'b0;
      step("ar_first");
      chk("ar_first.count", int'(c0), 1);

      // Randomized phase against the model
      for (int i = 0; i < 400; i++) begin
         logic [7:0] mv;
         case ($urandom_range(0, 5))
            0:       mv = 8'd0;
            1:       mv = 8'd255;
            2:       mv = 8'($urandom_range(1, 6));
            default: mv = 8'($urandom);
         endcase
         drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
               8'($urandom), mv);
         step($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/cfg_counter.md
CFG_COUNTER -- requirements
Module: cfg_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter SAT_MODE, default 0, where 0 = wrap at limits and 1 = saturate at limits.
REQ-003 Port clk, input, 1, SHALL be the clock; all state changes on posedge clk.
REQ-004 Port reset, input, 1, SHALL be the reset: asynchronous, active-high.
REQ-005 Port en, input, 1, SHALL be the count enable; step only when high.
REQ-006 Port up, input, 1, SHALL be the direction: 1 = increment, 0 = decrement.
REQ-007 Port clr, input, 1, SHALL be the synchronous clear of count.
REQ-008 Port load, input, 1, SHALL be the synchronous load strobe.
REQ-009 Port load_val, input, WIDTH, SHALL be the value loaded when load=1.
REQ-010 Port max_val, input, WIDTH, SHALL be the terminal value; the count range is 0..max_val inclusive.
REQ-011 Port sticky_clr, input, 1, SHALL clear both sticky flags.
REQ-012 Port count, output, WIDTH, SHALL be the registered counter value.
REQ-013 Port ovf, output, 1, SHALL be a registered one-cycle pulse on an up-limit event.
REQ-014 Port unf, output, 1, SHALL be a registered one-cycle pulse on a down-limit event.
REQ-015 Port ovf_sticky, output, 1, SHALL be a latched overflow flag.
REQ-016 Port unf_sticky, output, 1, SHALL be a latched underflow flag.
REQ-017 Port at_max, output, 1, SHALL be combinational and equal (count >= max_val).
REQ-018 Port at_zero, output, 1, SHALL be combinational and equal (count == 0).

Function
REQ-019 Per-cycle priority SHALL be clr > load > en; with none asserted, count holds.
REQ-020 clr=1 SHALL set count to 0 next cycle with ovf=unf=0, regardless of en/load.
REQ-021 load=1 (clr=0) SHALL set count to min(load_val, max_val) next cycle with ovf=unf=0.
REQ-022 en=1, up=1, count < max_val SHALL increment count by 1 with ovf=0.
REQ-023 en=1, up=1, count >= max_val SHALL set ovf=1 next cycle; count becomes 0 if SAT_MODE=0, or max_val if SAT_MODE=1.
REQ-024 en=1, up=0, count > 0 SHALL decrement count by 1 with unf=0.
REQ-025 en=1, up=0, count == 0 SHALL set unf=1 next cycle; count becomes max_val if SAT_MODE=0, or stays 0 if SAT_MODE=1.
REQ-026 In every cycle without a limit event (REQ-023 or REQ-025), ovf and unf SHALL be 0; they SHALL never both be 1.
REQ-027 Latency SHALL be 1 clock from input sample to updated count/ovf/unf; ovf/unf SHALL be coincident with the resulting count value.
REQ-028 When max_val == 0, every enabled step SHALL be a limit event: up gives ovf and down gives unf, with count remaining 0.
REQ-029 When max_val == all-ones, wrap SHALL be the natural modulo-2^WIDTH wrap.
REQ-030 When max_val drops below the current count, count SHALL hold until the next step; an up step is treated as at-limit (REQ-023) and a down step decrements normally.
REQ-031 ovf_sticky SHALL set in the cycle after ovf is generated (same edge as ovf) and hold until sticky_clr; unf_sticky SHALL behave the same way for unf.
REQ-032 When sticky_clr coincides with a new limit event, the set SHALL win.
REQ-033 Arithmetic SHALL be WIDTH bits unsigned with no carry-out exposed other than via ovf/unf.

Reset
REQ-034 reset=1 SHALL immediately, without waiting for a clock, force count=0, ovf=0, unf=0, ovf_sticky=0 and unf_sticky=0.
REQ-035 Reset asserted mid-count SHALL abort any pending step; after release, the first edge SHALL behave per Function from count=0.
REQ-036 Deassertion of reset SHALL be assumed synchronous to clk by the integrator; the block adds no synchroniser.

Verification
REQ-037 WIDTH=4, SAT_MODE=0, max_val=15, en=up=1 for 17 cycles -> count 1..15, then 0 with ovf=1 for exactly one cycle, then 1; ovf_sticky=1 from the wrap onward.
REQ-038 WIDTH=8, SAT_MODE=0, max_val=9, count=0, en=1, up=0 -> count=9 with unf=1 one cycle; next cycle count=8 with unf=0.
REQ-039 SAT_MODE=1, max_val=5, count=5, up=1, 3 enabled cycles -> count stays 5 and ovf=1 each cycle.
REQ-040 Same cycle clr=1, load=1 (load_val=7), en=1 -> count=0; next cycle load=1 alone with max_val=4, load_val=7 -> count=4.
REQ-041 sticky_clr=1 in the same cycle as a wrap -> ovf_sticky=1 after the edge; sticky_clr alone on the next cycle -> ovf_sticky=0.
REQ-042 Assert reset asynchronously between edges with count=3 -> count=0 and all flags 0 before the next edge; release, en=up=1 -> count=1 on the next edge.
